load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage controller sitting directly upstream of the data memory with stack.
- Takes one decoded load/store/stack request from execute and computes the effective address (base + sign-extended imm16).
- Owns the architectural stack pointer, drives the memory read/write strobes, waits for a memory acknowledge, and returns writeback results.
- Flags misalignment, stack overflow/underflow and memory timeout without touching memory.

Parameters:
- STACK_TOP, 32'd4096: reset value of sp, one past the highest stack word.
- STACK_BASE, 32'd3072: lowest legal stack word address.
- TIMEOUT, 16: maximum cycles spent waiting for mem_ack before error; must be ≥1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- opcode  in  6  LW=000101, LW.POI=000110, SW=000111, PUSH=001111, POP=010000
- base  in  32  Rs1 value
- store_data  in  32  Rs2 value for SW/PUSH
- imm16  in  16  signed offset
- rd  in  5  destination for LW/LW.POI/POP
- rs1  in  5  base register index (LW.POI update)
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  access complete
- wb_valid  out  1  one-cycle result pulse
- wb_rd  out  5  destination register
- wb_data  out  32  loaded word
- inc_valid  out  1  one-cycle LW.POI base-update pulse
- inc_rd  out  5  equals latched rs1
- inc_data  out  32  latched base + 4
- sp  out  32  current stack pointer
- done  out  1  one-cycle pulse, every accepted request ends here
- err  out  1  valid with done; request aborted

Behaviour:
- Reset values:
  - State IDLE, sp=STACK_TOP, req_ready=1.
  - All strobes/pulses and err are 0; mem_addr, mem_wdata, wb_* and inc_* are 0.
  - Reset has priority in every state; an in-flight access is abandoned with no done and no sp change.
- Accept on req_valid && req_ready (cycle N). Opcode, operands, rd and rs1 are latched; req_ready drops at N+1.
- Effective address:
  - LW/LW.POI/SW: ea = base + {{16{imm16[15]}},imm16}, modulo 2^32.
  - PUSH: ea = sp−4.
  - POP: ea = sp.
- Checks at accept, in priority order:
  - ea[1:0]≠0 → misalign.
  - PUSH with sp−4 < STACK_BASE → overflow.
  - POP with sp ≥ STACK_TOP → underflow.
  - Unknown opcode → illegal.
  - Any check failing → CHECK_FAIL state: done=1 and err=1 at N+1, no strobes, sp unchanged.
- States:
  - IDLE: waits for accept, as above.
  - ACCESS:
    - Entered at N+1 on a passing check.
    - mem_read (LW/LW.POI/POP) or mem_write (SW/PUSH) is held high with stable mem_addr/mem_wdata until the cycle mem_ack is sampled high.
    - A wait counter starts at 0 on entry and increments each cycle without ack. Counter reaching TIMEOUT without ack → RESP with err.
  - RESP:
    - Entered the cycle after ack; strobes low, done=1 for exactly one cycle, then IDLE.
    - Loads: wb_valid=1, wb_rd=rd, wb_data=mem_rdata captured on the ack cycle.
    - LW.POI additionally: inc_valid=1, inc_rd=rs1, inc_data=base+4 (wraps).
    - If rd==rs1 on LW.POI, both pulses are still issued; the register file gives the load priority.
- sp update:
  - PUSH: sp ← sp−4 on the ack cycle.
  - POP: sp ← sp+4 on the ack cycle.
  - Timeout or error leaves sp unchanged.
- Minimum latency: ack in first ACCESS cycle (N+1) → done at N+2. One request in flight at a time.
- mem_ack outside ACCESS is ignored.

Test Plan:
- LW, base=0x100, imm16=0xFFFC, mem_ack at N+1 with mem_rdata=0xDEADBEEF → mem_addr=0xFC, mem_read high 1 cycle, wb_valid/done at N+2, wb_data=0xDEADBEEF, err=0.
- PUSH 0x11223344 then POP rd=7, immediate acks →
  - PUSH: mem_addr=4092, mem_wdata=0x11223344, sp becomes 4092.
  - POP: mem_addr=4092, wb_rd=7, sp back to 4096.
- POP at reset (sp=4096) → done and err at N+1, no strobe, sp=4096. Fill until sp=3072; next PUSH → err, sp stays 3072.
- LW.POI, rs1=3, base=0x200, imm16=8, rd=5, ack after 3 wait cycles →
  - mem_addr=0x208, mem_read held 4 cycles.
  - wb_rd=5 and inc_rd=3, inc_data=0x204 in the same cycle.
- SW to base=0x102 → misalign error at N+1, no mem_write. SW with mem_ack never asserted → err after TIMEOUT=16 wait cycles, then req_ready=1.
- rst_n low during ACCESS after PUSH accept → next cycle IDLE, strobes 0, sp=STACK_TOP, no done pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store/stack controller: computes effective addresses, owns
// the stack pointer, runs a single memory handshake with timeout, returns writeback.
module load_store_unit #(
    parameter logic [31:0] STACK_TOP  = 32'd4096,
    parameter logic [31:0] STACK_BASE = 32'd3072,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] base,
    input  logic [31:0] store_data,
    input  logic [15:0] imm16,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        inc_valid,
    output logic [4:0]  inc_rd,
    output logic [31:0] inc_data,
    output logic [31:0] sp,
    output logic        done,
    output logic        err
);

    localparam logic [5:0] OP_LW     = 6'b000101;
    localparam logic [5:0] OP_LW_POI = 6'b000110;
    localparam logic [5:0] OP_SW     = 6'b000111;
    localparam logic [5:0] OP_PUSH   = 6'b001111;
    localparam logic [5:0] OP_POP    = 6'b010000;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        CHECK_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         op_q;
    logic [31:0]        base_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [31:0]        sp_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_q;

    logic [31:0] imm_ext;
    logic [31:0] ea;
    logic        known_op;
    logic        check_fail;
    logic        accept;
    logic        is_load_q;
    logic        timeout_hit;

    assign imm_ext   = {{16{imm16[15]}}, imm16};
    assign accept    = req_valid && (state_q == IDLE);
    assign is_load_q = (op_q == OP_LW) || (op_q == OP_LW_POI) || (op_q == OP_POP);
    assign timeout_hit = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        ea       = base + imm_ext;
        known_op = 1'b1;
        case (opcode)
            OP_LW, OP_LW_POI, OP_SW: ea = base + imm_ext;
            OP_PUSH:                 ea = sp_q - 32'd4;
            OP_POP:                  ea = sp_q;
            default:                 known_op = 1'b0;
        endcase
    end

    // Misalign, overflow, underflow and illegal opcode all abort the same way.
    assign check_fail = (ea[1:0] != 2'b00)
                     || ((opcode == OP_PUSH) && ((sp_q - 32'd4) < STACK_BASE))
                     || ((opcode == OP_POP) && (sp_q >= STACK_TOP))
                     || !known_op;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (accept) state_d = check_fail ? CHECK_FAIL : ACCESS;
            ACCESS:     if (mem_ack || timeout_hit) state_d = RESP;
            RESP:       state_d = IDLE;
            CHECK_FAIL: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            base_q   <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sp_q     <= STACK_TOP;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= opcode;
                        base_q   <= base;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        addr_q   <= ea;
                        wdata_q  <= store_data;
                        wait_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        if (op_q == OP_PUSH) sp_q <= sp_q - 32'd4;
                        if (op_q == OP_POP)  sp_q <= sp_q + 32'd4;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_read  = (state_q == ACCESS) && is_load_q;
    assign mem_write = (state_q == ACCESS) && !is_load_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign sp        = sp_q;

    assign done      = (state_q == RESP) || (state_q == CHECK_FAIL);
    assign err       = (state_q == CHECK_FAIL) || ((state_q == RESP) && err_q);

    assign wb_valid  = (state_q == RESP) && !err_q && is_load_q;
    assign wb_rd     = wb_valid ? rd_q : 5'd0;
    assign wb_data   = wb_valid ? rdata_q : 32'd0;

    // Post-increment of the base register rides alongside the load result.
    assign inc_valid = (state_q == RESP) && !err_q && (op_q == OP_LW_POI);
    assign inc_rd    = inc_valid ? rs1_q : 5'd0;
    assign inc_data  = inc_valid ? (base_q + 32'd4) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued when a
// request is driven and compared when the unit signals done.
module tb_load_store_unit;

    localparam logic [5:0] OP_LW     = 6'b000101;
    localparam logic [5:0] OP_LW_POI = 6'b000110;
    localparam logic [5:0] OP_SW     = 6'b000111;
    localparam logic [5:0] OP_PUSH   = 6'b001111;
    localparam logic [5:0] OP_POP    = 6'b010000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] base;
    logic [31:0] store_data;
    logic [15:0] imm16;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        inc_valid;
    logic [4:0]  inc_rd;
    logic [31:0] inc_data;
    logic [31:0] sp;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .base(base), .store_data(store_data), .imm16(imm16),
        .rd(rd), .rs1(rs1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .inc_valid(inc_valid), .inc_rd(inc_rd), .inc_data(inc_data),
        .sp(sp), .done(done), .err(err)
    );

    typedef struct {
        logic        err;
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        inc_valid;
        logic [4:0]  inc_rd;
        logic [31:0] inc_data;
        logic [31:0] sp;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_write;
        int          strobes;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic e, input logic wv, input logic [4:0] wr,
                                input logic [31:0] wd, input logic iv, input logic [4:0] ir,
                                input logic [31:0] id, input logic [31:0] s,
                                input logic [31:0] a, input logic [31:0] w,
                                input logic wr_op, input int n);
        exp_t x;
        x.err = e; x.wb_valid = wv; x.wb_rd = wr; x.wb_data = wd;
        x.inc_valid = iv; x.inc_rd = ir; x.inc_data = id; x.sp = s;
        x.addr = a; x.wdata = w; x.is_write = wr_op; x.strobes = n;
        return x;
    endfunction

    // ack_wait: strobe cycles without ack before the ack cycle; negative never acks.
    task automatic do_req(input string tag, input logic [5:0] op, input logic [31:0] b,
                          input logic [31:0] sd, input logic [15:0] imm,
                          input logic [4:0] r_d, input logic [4:0] r_s1,
                          input int ack_wait, input logic [31:0] rdata, input exp_t e);
        exp_t x;
        int   n;
        int   strobes;
        int   lat_exp;
        bit   seen;
        sb.push_back(e);
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; opcode = op; base = b; store_data = sd;
        imm16 = imm; rd = r_d; rs1 = r_s1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1; strobes = 0; seen = 0;
        while (n <= 40 && !seen) begin
            if (mem_read || mem_write) begin
                strobes++;
                x = sb[0];
                check({tag, ".addr"}, mem_addr, x.addr);
                check({tag, ".dir"}, {30'd0, mem_write, mem_read}, {30'd0, x.is_write, !x.is_write});
                if (x.is_write) check({tag, ".wdata"}, mem_wdata, x.wdata);
                mem_ack   = (ack_wait >= 0) && (strobes > ack_wait);
                mem_rdata = mem_ack ? rdata : (32'hBAD0_0000 + 32'(strobes));
            end
            if (done) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check({tag, ".sb_empty"}, 32'd1, 32'd0);
                end else begin
                    x = sb.pop_front();
                    lat_exp = (x.strobes == 0) ? 1 : x.strobes + 1;
                    check({tag, ".latency"}, 32'(n), 32'(lat_exp));
                    check({tag, ".strobes"}, 32'(strobes), 32'(x.strobes));
                    check({tag, ".err"}, {31'd0, err}, {31'd0, x.err});
                    check({tag, ".sp"}, sp, x.sp);
                    check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, x.wb_valid});
                    check({tag, ".inc_valid"}, {31'd0, inc_valid}, {31'd0, x.inc_valid});
                    if (x.wb_valid) begin
                        check({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, x.wb_rd});
                        check({tag, ".wb_data"}, wb_data, x.wb_data);
                    end
                    if (x.inc_valid) begin
                        check({tag, ".inc_rd"}, {27'd0, inc_rd}, {27'd0, x.inc_rd});
                        check({tag, ".inc_data"}, inc_data, x.inc_data);
                    end
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            n++;
        end
        if (!seen) begin
            check({tag, ".done_seen"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] sp_exp;
        rst_n = 1'b0; req_valid = 1'b0; opcode = '0; base = '0; store_data = '0;
        imm16 = '0; rd = '0; rs1 = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready", {31'd0, req_ready}, 32'd1);
        check("reset.sp", sp, 32'd4096);
        check("reset.strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("reset.done_err", {30'd0, done, err}, 32'd0);
        check("reset.addr", mem_addr, 32'd0);
        check("reset.wdata", mem_wdata, 32'd0);
        check("reset.pulses", {30'd0, wb_valid, inc_valid}, 32'd0);
        rst_n = 1'b1;

        do_req("lw_neg_imm", OP_LW, 32'h100, 32'h0, 16'hFFFC, 5'd2, 5'd1, 0, 32'hDEADBEEF,
               mk(0, 1, 5'd2, 32'hDEADBEEF, 0, 0, 0, 32'd4096, 32'h0FC, 0, 0, 1));
        do_req("push", OP_PUSH, 32'h0, 32'h11223344, 16'h0, 5'd0, 5'd0, 0, 32'h0,
               mk(0, 0, 0, 0, 0, 0, 0, 32'd4092, 32'd4092, 32'h11223344, 1, 1));
        do_req("pop", OP_POP, 32'h0, 32'h0, 16'h0, 5'd7, 5'd0, 0, 32'h11223344,
               mk(0, 1, 5'd7, 32'h11223344, 0, 0, 0, 32'd4096, 32'd4092, 0, 0, 1));
        do_req("pop_underflow", OP_POP, 32'h0, 32'h0, 16'h0, 5'd7, 5'd0, 0, 32'h0,
               mk(1, 0, 0, 0, 0, 0, 0, 32'd4096, 0, 0, 0, 0));
        do_req("lw_poi_wait3", OP_LW_POI, 32'h200, 32'h0, 16'd8, 5'd5, 5'd3, 3, 32'hCAFEF00D,
               mk(0, 1, 5'd5, 32'hCAFEF00D, 1, 5'd3, 32'h204, 32'd4096, 32'h208, 0, 0, 4));
        do_req("lw_poi_wrap", OP_LW_POI, 32'hFFFF_FFFC, 32'h0, 16'h0010, 5'd9, 5'd9, 1, 32'h0BADF00D,
               mk(0, 1, 5'd9, 32'h0BADF00D, 1, 5'd9, 32'h0, 32'd4096, 32'h00C, 0, 0, 2));
        do_req("sw_misalign", OP_SW, 32'h102, 32'h55, 16'h0, 5'd0, 5'd0, 0, 32'h0,
               mk(1, 0, 0, 0, 0, 0, 0, 32'd4096, 0, 0, 1, 0));
        do_req("illegal_op", 6'b111111, 32'h100, 32'h0, 16'h0, 5'd1, 5'd1, 0, 32'h0,
               mk(1, 0, 0, 0, 0, 0, 0, 32'd4096, 0, 0, 0, 0));
        do_req("sw_timeout", OP_SW, 32'h300, 32'hA5A5_5A5A, 16'h0, 5'd0, 5'd0, -1, 32'h0,
               mk(1, 0, 0, 0, 0, 0, 0, 32'd4096, 32'h300, 32'hA5A5_5A5A, 1, 16));
        do_req("lw_timeout", OP_LW, 32'h400, 32'h0, 16'h4, 5'd4, 5'd0, -1, 32'h0,
               mk(1, 0, 0, 0, 0, 0, 0, 32'd4096, 32'h404, 0, 0, 16));

        // Stray ack while idle must not disturb anything.
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        check("stray_ack.done", {31'd0, done}, 32'd0);
        check("stray_ack.sp", sp, 32'd4096);

        sp_exp = 32'd4096;
        for (int i = 0; i < 256; i++) begin
            sp_exp = sp_exp - 32'd4;
            do_req("fill", OP_PUSH, 32'h0, 32'(i), 16'h0, 5'd0, 5'd0, 0, 32'h0,
                   mk(0, 0, 0, 0, 0, 0, 0, sp_exp, sp_exp, 32'(i), 1, 1));
        end
        check("fill.sp", sp, 32'd3072);
        do_req("push_overflow", OP_PUSH, 32'h0, 32'hFFFF_0000, 16'h0, 5'd0, 5'd0, 0, 32'h0,
               mk(1, 0, 0, 0, 0, 0, 0, 32'd3072, 0, 0, 1, 0));
        do_req("pop_top", OP_POP, 32'h0, 32'h0, 16'h0, 5'd12, 5'd0, 0, 32'h0000_0000,
               mk(0, 1, 5'd12, 32'h0, 0, 0, 0, 32'd3076, 32'd3072, 0, 0, 1));

        // Reset in the middle of a PUSH access.
        @(negedge clk);
        req_valid = 1'b1; opcode = OP_PUSH; store_data = 32'h7777_7777;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid.in_access", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid.ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid.strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mid.done", {31'd0, done}, 32'd0);
        check("rst_mid.sp", sp, 32'd4096);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.after", {29'd0, done, mem_write, mem_read}, 32'd0);

        do_req("post_reset_push", OP_PUSH, 32'h0, 32'h0102_0304, 16'h0, 5'd0, 5'd0, 2, 32'h0,
               mk(0, 0, 0, 0, 0, 0, 0, 32'd4092, 32'd4092, 32'h0102_0304, 1, 3));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
